// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder
//   Single-lane DVI/HDMI TMDS encoder. It turns one 8-bit pixel (or 2-bit
//   control word) into a 10-bit DC-balanced symbol every enabled pixel clock.
//   There are two register stages:
//     stage 1 : q_m transition-minimised word, with de/ctrl delayed alongside
//     stage 2 : DC balancing against the running disparity, plus control codes
//
//   Parameter
//     INVERT_OUT : 1 = invert all 10 tmds bits, for a board-level P/N swap.
//                  The inversion is applied after encoding, so disparity
//                  tracking is unaffected.
//   Optional build macro
//     TMDS_TERC4_EN : adds the island/aux inputs and TERC4 data-island
//                     symbols. Priority is de > island > control.
//   Ports
//     clk    in   pixel clock
//     reset  in   synchronous, active-high; overrides ce
//     ce     in   clock enable; 0 holds every register
//     de     in   display enable (1 = video period)
//     data   in   [7:0] pixel byte
//     ctrl   in   [1:0] {C1,C0}
//     island in   (TMDS_TERC4_EN) data-island period
//     aux    in   [3:0] (TMDS_TERC4_EN) TERC4 nibble
//     tmds   out  [9:0] encoded symbol, bit 0 is transmitted first
//     disp   out  [4:0] signed running disparity after the current symbol
module tmds_channel_encoder #(
   parameter bit INVERT_OUT = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              de,
   input  logic [7:0]        data,
   input  logic [1:0]        ctrl,
`ifdef TMDS_TERC4_EN
   input  logic              island,
   input  logic [3:0]        aux,
`endif
   output logic [9:0]        tmds,
   output logic signed [4:0] disp
);

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] INV_MASK = {10{INVERT_OUT}};

   // stage 1 registers
   logic [8:0]        r_qm;
   logic              r_de;
   logic [1:0]        r_ctrl;
`ifdef TMDS_TERC4_EN
   logic              r_island;
   logic [3:0]        r_aux;
`endif
   // stage 2 registers
   logic [9:0]        r_tmds;
   logic signed [4:0] r_cnt;

   // stage 1 combinational: popcount and XOR/XNOR chain
   logic [3:0]        w_n1d;
   logic              w_use_xnor;
   logic [8:0]        w_qm;

   always_comb begin
      logic v_acc;
      w_n1d = '0;
      for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b000, data[i]};
      // The tie case (four ones) is broken on data[0] so the choice is deterministic.
      w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !data[0]);
      v_acc   = data[0];
      w_qm[0] = v_acc;
      for (int i = 1; i < 8; i++) begin
         v_acc   = w_use_xnor ? ~(v_acc ^ data[i]) : (v_acc ^ data[i]);
         w_qm[i] = v_acc;
      end
      w_qm[8] = ~w_use_xnor;
   end

   // stage 2 combinational: balance of q_m[7:0] as (ones - zeros) = 2*n1q - 8
   logic [3:0]        w_n1q;
   logic signed [4:0] w_bal;
   logic signed [4:0] w_two_q;
   logic signed [4:0] w_two_nq;
   logic              w_cnt_pos, w_cnt_neg, w_bal_pos, w_bal_neg;
   logic [9:0]        w_sym;
   logic signed [4:0] w_cnt_nxt;

   always_comb begin
      w_n1q = '0;
      for (int i = 0; i < 8; i++) w_n1q = w_n1q + {3'b000, r_qm[i]};
   end

   // 2*8 wraps to -16 in 5 bits, and subtracting 8 wraps back to +8, so the
   // 5-bit result is exact over the whole range -8..+8.
   assign w_bal     = $signed({w_n1q, 1'b0}) - 5'sd8;
   assign w_two_q   = r_qm[8] ? 5'sd2 : 5'sd0;
   assign w_two_nq  = r_qm[8] ? 5'sd0 : 5'sd2;
   assign w_cnt_neg = r_cnt[4];
   assign w_cnt_pos = !r_cnt[4] && (r_cnt != 5'sd0);
   assign w_bal_neg = w_bal[4];
   assign w_bal_pos = !w_bal[4] && (w_bal != 5'sd0);

   // The encoding keeps |cnt| <= 10, so the 5-bit signed counter cannot
   // overflow and no saturation is needed.
   always_comb begin
      w_sym     = CTRL_00;
      w_cnt_nxt = 5'sd0;
      if (r_de) begin
         if ((r_cnt == 5'sd0) || (w_bal == 5'sd0)) begin
            w_sym     = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
            w_cnt_nxt = r_qm[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
         end else if ((w_cnt_pos && w_bal_pos) || (w_cnt_neg && w_bal_neg)) begin
            w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + w_two_q - w_bal;
         end else begin
            w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_nxt = r_cnt + w_bal - w_two_nq;
         end
      end
`ifdef TMDS_TERC4_EN
      else if (r_island) begin
         case (r_aux)
            4'h0:    w_sym = 10'b1010011100;
            4'h1:    w_sym = 10'b1001100011;
            4'h2:    w_sym = 10'b1011100100;
            4'h3:    w_sym = 10'b1011100010;
            4'h4:    w_sym = 10'b0101110001;
            4'h5:    w_sym = 10'b0100011110;
            4'h6:    w_sym = 10'b0110001110;
            4'h7:    w_sym = 10'b0100111100;
            4'h8:    w_sym = 10'b1011001100;
            4'h9:    w_sym = 10'b0100111001;
            4'hA:    w_sym = 10'b0110011100;
            4'hB:    w_sym = 10'b1011000110;
            4'hC:    w_sym = 10'b1010001110;
            4'hD:    w_sym = 10'b1001110001;
            4'hE:    w_sym = 10'b0101100011;
            default: w_sym = 10'b1011000011;
         endcase
      end
`endif
      else begin
         case (r_ctrl)
            2'b00:   w_sym = 10'b1101010100;
            2'b01:   w_sym = 10'b0010101011;
            2'b10:   w_sym = 10'b0101010100;
            default: w_sym = 10'b1010101011;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_qm     <= '0;
         r_de     <= 1'b0;
         r_ctrl   <= 2'b00;
`ifdef TMDS_TERC4_EN
         r_island <= 1'b0;
         r_aux    <= '0;
`endif
         r_tmds   <= CTRL_00 ^ INV_MASK;
         r_cnt    <= 5'sd0;
      end else if (ce) begin
         r_qm     <= w_qm;
         r_de     <= de;
         r_ctrl   <= ctrl;
`ifdef TMDS_TERC4_EN
         r_island <= island;
         r_aux    <= aux;
`endif
         r_tmds   <= w_sym ^ INV_MASK;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign tmds = r_tmds;
   assign disp = r_cnt;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder. It uses a behavioural reference model
// (integer arithmetic over the encoding rules plus a two-deep enabled-cycle
// pipeline), an independent TMDS decoder, and a per-burst disparity
// accumulator. Literal expectations pin the reset, zero-data and control cases.
module tb_tmds_channel_encoder;

   logic              clk = 1'b0;
   logic              reset, ce, de;
   logic [7:0]        data;
   logic [1:0]        ctrl;
   logic              island;
   logic [3:0]        aux;
   logic [9:0]        tmds;
   logic signed [4:0] disp;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tmds_channel_encoder #(.INVERT_OUT(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .de    (de),
      .data  (data),
      .ctrl  (ctrl),
`ifdef TMDS_TERC4_EN
      .island(island),
      .aux   (aux),
`endif
      .tmds  (tmds),
      .disp  (disp)
   );

   typedef struct {
      logic       de;
      logic [7:0] data;
      logic [1:0] ctrl;
      logic       island;
      logic [3:0] aux;
   } in_t;

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] t [4];
      t[0] = 10'h354; t[1] = 10'h0AB; t[2] = 10'h154; t[3] = 10'h2AB;
      return t[c];
   endfunction

   function automatic logic [9:0] terc4_code(input logic [3:0] a);
      logic [9:0] t [16];
      t[0]  = 10'b1010011100; t[1]  = 10'b1001100011; t[2]  = 10'b1011100100; t[3]  = 10'b1011100010;
      t[4]  = 10'b0101110001; t[5]  = 10'b0100011110; t[6]  = 10'b0110001110; t[7]  = 10'b0100111100;
      t[8]  = 10'b1011001100; t[9]  = 10'b0100111001; t[10] = 10'b0110011100; t[11] = 10'b1011000110;
      t[12] = 10'b1010001110; t[13] = 10'b1001110001; t[14] = 10'b0101100011; t[15] = 10'b1011000011;
      return t[a];
   endfunction

   // Reference encoding of one symbol from the rules, using integer disparity.
   function automatic logic [9:0] enc(input in_t x, input int cnt, output int cnt_o);
      logic [7:0] qm;
      logic       qm8, inv;
      int         n1, diff;
      cnt_o = 0;
      if (!x.de) begin
`ifdef TMDS_TERC4_EN
         if (x.island) return terc4_code(x.aux);
`endif
         return ctrl_code(x.ctrl);
      end
      n1  = $countones(x.data);
      inv = (n1 > 4) || (n1 == 4 && !x.data[0]);
      qm[0] = x.data[0];
      for (int i = 1; i < 8; i++) qm[i] = x.data[i] ^ qm[i-1] ^ inv;
      qm8  = !inv;
      diff = 2 * $countones(qm) - 8;
      if (cnt == 0 || diff == 0) begin
         cnt_o = qm8 ? cnt + diff : cnt - diff;
         return {~qm8, qm8, (qm8 ? qm : ~qm)};
      end else if ((cnt > 0 && diff > 0) || (cnt < 0 && diff < 0)) begin
         cnt_o = cnt + 2 * int'(qm8) - diff;
         return {1'b1, qm8, ~qm};
      end
      cnt_o = cnt + diff - 2 * int'(!qm8);
      return {1'b0, qm8, qm};
   endfunction

   // Independent TMDS video decoder.
   function automatic logic [7:0] dec(input logic [9:0] s);
      logic [7:0] q, d;
      q = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ !s[8];
      return d;
   endfunction

   // model state
   in_t        s1;
   logic [9:0] exp_tmds;
   int         exp_cnt;
   logic       exp_de;
   logic [7:0] exp_data;
   bit         started = 0;
   bit         upd = 0;
   int         burst = 0;

   initial forever begin
      in_t cur;
      int  nc;
      @(posedge clk);
      cur.de = de; cur.data = data; cur.ctrl = ctrl; cur.island = island; cur.aux = aux;
      upd = 0;
      if (reset) begin
         s1.de = 0; s1.data = 0; s1.ctrl = 0; s1.island = 0; s1.aux = 0;
         exp_tmds = 10'h354; exp_cnt = 0; exp_de = 0; exp_data = 0;
         started = 1; upd = 1;
      end else if (ce && started) begin
         exp_tmds = enc(s1, exp_cnt, nc);
         exp_cnt  = nc;
         exp_de   = s1.de;
         exp_data = s1.data;
         s1 = cur;
         upd = 1;
      end
   end

   // per-cycle compare against the model, away from the active edge
   initial forever begin
      @(negedge clk);
      if (started) begin
         n_cmp++;
         if (tmds !== exp_tmds || int'(disp) != exp_cnt) begin
            n_fail++;
            $display("FAIL model t=%0t tmds=%h disp=%0d expected tmds=%h disp=%0d",
                     $time, tmds, disp, exp_tmds, exp_cnt);
         end
         if (upd && exp_de) begin
            burst += 2 * $countones(tmds) - 10;
            n_cmp++;
            if (dec(tmds) !== exp_data) begin
               n_fail++;
               $display("FAIL decode t=%0t got=%h expected=%h", $time, dec(tmds), exp_data);
            end
            n_cmp++;
            if (int'(disp) != burst || disp > 5'sd10 || disp < -5'sd10) begin
               n_fail++;
               $display("FAIL burst_disp t=%0t disp=%0d expected=%0d (|disp|<=10)", $time, disp, burst);
            end
         end else if (upd) begin
            burst = 0;
         end
      end
   end

   task automatic drive(input bit c, input bit d, input logic [7:0] dt, input logic [1:0] ct);
      ce = c; de = d; data = dt; ctrl = ct;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [9:0] et, input int ed);
      n_cmp++;
      if (tmds !== et || int'(disp) != ed) begin
         n_fail++;
         $display("FAIL %s tmds=%h disp=%0d expected tmds=%h disp=%0d", nm, tmds, disp, et, ed);
      end
   endtask

   initial begin
      int left;
      bit vid;
      reset = 1; ce = 1; de = 0; data = 0; ctrl = 0; island = 0; aux = 0;
      repeat (3) drive(1, 0, 8'h00, 2'b00);
      chk("reset", 10'h354, 0);
      reset = 0;
      repeat (3) drive(1, 0, 8'h00, 2'b00);

      // zero data after a control period
      drive(1, 1, 8'h00, 2'b00);
      drive(1, 1, 8'h00, 2'b00);
      chk("zero0", 10'h100, -8);
      drive(1, 1, 8'h00, 2'b00);
      chk("zero1", 10'h3FF, 2);
      drive(1, 0, 8'h00, 2'b00);
      chk("zero2", 10'h100, -6);

      // control codes
      drive(1, 0, 8'h00, 2'b01);
      chk("ctrl00", 10'h354, 0);
      drive(1, 0, 8'h00, 2'b10);
      chk("ctrl01", 10'h0AB, 0);
      drive(1, 0, 8'h00, 2'b11);
      chk("ctrl10", 10'h154, 0);
      drive(1, 0, 8'h00, 2'b00);
      chk("ctrl11", 10'h2AB, 0);

      // ce=0 holds tmds and disp
      drive(1, 1, 8'h00, 2'b00);
      drive(1, 1, 8'hFF, 2'b00);
      drive(0, 1, 8'h55, 2'b00);
      chk("hold", 10'h100, -8);
      drive(0, 1, 8'h55, 2'b00);
      chk("hold2", 10'h100, -8);

      // single-cycle de pulse, then reset mid-video (also with ce=0)
      drive(1, 0, 8'h00, 2'b00);
      drive(1, 1, 8'hA5, 2'b00);
      drive(1, 0, 8'h00, 2'b00);
      drive(1, 1, 8'h3C, 2'b00);
      drive(1, 1, 8'h81, 2'b00);
      reset = 1;
      drive(0, 1, 8'h81, 2'b00);
      chk("reset_mid", 10'h354, 0);
      reset = 0;
      drive(1, 1, 8'h00, 2'b00);
      chk("post_reset", 10'h354, 0);

      // random video bursts: full-rate, ce toggling, then random ce
      left = 0; vid = 0;
      for (int i = 0; i < 10000; i++) begin
         bit c;
         if (left == 0) begin
            vid  = !vid;
            left = vid ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
         end
         left--;
         c = (i < 4000) ? 1'b1 : (i < 7000) ? 1'(i & 1) : ($urandom_range(0, 3) != 0);
         drive(c, vid, 8'($urandom), 2'($urandom));
      end

`ifdef TMDS_TERC4_EN
      drive(1, 0, 8'h00, 2'b00);
      island = 1;
      for (int a = 0; a < 16; a++) begin
         aux = 4'(a);
         drive(1, 0, 8'h00, 2'b00);
         if (a > 0) chk("terc4", terc4_code(4'(a - 1)), 0);
      end
      drive(1, 1, 8'h00, 2'b00);
      chk("terc4_last", terc4_code(4'hF), 0);
      drive(1, 0, 8'h00, 2'b00);
      chk("de_wins", 10'h100, -8);
      island = 0;
`endif

      repeat (4) drive(1, 0, 8'h00, 2'b00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
